keypad_entry_ctrl: RTL and testbench

// Scan/debounce/entry controller for the 3x4 keypad and the 6-digit multiplexed 7-segment display.
// - Sequences keypad rows, decodes one key per scan frame and debounces it into single key events.
// - Assembles up to 6 BCD digits, with '*' = backspace and '#' = enter.
// - Time-multiplexes the digit buffer onto the display.

---
 rtl/keypad_entry_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// Keypad scan/debounce/entry controller driving a 6-digit multiplexed 7-segment display.
// Keys are resolved per 3-row scan frame, debounced into single events and assembled as BCD.
module keypad_entry_ctrl #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REFRESH_DIV    = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  keypadCol,
    output logic [2:0]  keypadRow,
    output logic [5:0]  segmentSelect,
    output logic [7:0]  segmentData,
    output logic [23:0] entry_value,
    output logic        entry_valid,
    output logic [2:0]  entry_count
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DebW  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [ScanW-1:0] ScanLast  = ScanW'(SCAN_DIV - 1);
    localparam logic [RefW-1:0]  RefLast   = RefW'(REFRESH_DIV - 1);
    localparam logic [DebW-1:0]  DebTarget = DebW'(DEBOUNCE_SCANS);

    localparam logic [3:0] KeyStar = 4'hA;
    localparam logic [3:0] KeyHash = 4'hB;
    localparam logic [3:0] KeyNone = 4'hF;

    typedef enum logic [1:0] {StIdle, StPress, StHeld} deb_state_e;

    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       row_q, row_d;
    logic             scan_last;
    logic [3:0]       row_code;
    logic             row_hit, row_multi;
    logic             seen_q, seen_d, seen_n;
    logic             bad_q, bad_d, bad_n;
    logic [3:0]       code_q, code_d, code_n;
    logic             frame_done;
    logic [3:0]       frame_res;

    deb_state_e       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [DebW-1:0]  cnt_q, cnt_d;
    logic [DebW-1:0]  rcnt_q, rcnt_d;
    logic             key_evt_q, key_evt_d;
    logic [3:0]       key_code_q, key_code_d;

    logic [23:0]      digits_q, digits_d;
    logic [2:0]       count_q, count_d;
    logic [23:0]      value_q, value_d;
    logic             valid_q, valid_d;

    logic [RefW-1:0]  ref_cnt_q, ref_cnt_d;
    logic             ref_last;
    logic [2:0]       dig_idx_q, dig_idx_d;
    logic [5:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       nibble;

    function automatic logic [7:0] seg_pattern(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = 8'hFF;
        endcase
        return p;
    endfunction

    // Row drive rotates the low bit: 110 -> 101 -> 011 -> 110.
    always_comb begin
        scan_last  = (scan_cnt_q == ScanLast);
        scan_cnt_d = scan_last ? '0 : scan_cnt_q + ScanW'(1);
        row_d      = scan_last ? {row_q[1:0], row_q[2]} : row_q;
    end

    always_comb begin
        row_code = KeyNone;
        case ({row_q, keypadCol})
            7'b110_1110: row_code = 4'd1;
            7'b110_1101: row_code = 4'd2;
            7'b110_1011: row_code = 4'd3;
            7'b110_0111: row_code = KeyStar;
            7'b101_1110: row_code = 4'd4;
            7'b101_1101: row_code = 4'd5;
            7'b101_1011: row_code = 4'd6;
            7'b101_0111: row_code = KeyHash;
            7'b011_1110: row_code = 4'd7;
            7'b011_1101: row_code = 4'd8;
            7'b011_1011: row_code = 4'd9;
            7'b011_0111: row_code = 4'd0;
            default:     row_code = KeyNone;
        endcase
        row_hit   = (row_code != KeyNone);
        // Any low column that did not decode to a single key means several columns low.
        row_multi = (keypadCol != 4'hF) && !row_hit;
    end

    always_comb begin
        seen_n     = seen_q | row_hit;
        bad_n      = bad_q | row_multi | (seen_q & row_hit);
        code_n     = row_hit ? row_code : code_q;
        seen_d     = seen_q;
        bad_d      = bad_q;
        code_d     = code_q;
        frame_done = 1'b0;
        frame_res  = KeyNone;
        if (scan_last) begin
            if (row_q == 3'b011) begin
                frame_done = 1'b1;
                frame_res  = (seen_n && !bad_n) ? code_n : KeyNone;
                seen_d     = 1'b0;
                bad_d      = 1'b0;
                code_d     = KeyNone;
            end else begin
                seen_d = seen_n;
                bad_d  = bad_n;
                code_d = code_n;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        rcnt_d     = rcnt_q;
        key_evt_d  = 1'b0;
        key_code_d = key_code_q;
        if (frame_done) begin
            case (state_q)
                StIdle: begin
                    if (frame_res != KeyNone) begin
                        cand_d  = frame_res;
                        cnt_d   = DebW'(1);
                        state_d = StPress;
                    end
                end
                StPress: begin
                    if (frame_res == cand_q) begin
                        if (cnt_q + DebW'(1) == DebTarget) begin
                            key_evt_d  = 1'b1;
                            key_code_d = cand_q;
                            rcnt_d     = '0;
                            state_d    = StHeld;
                        end else begin
                            cnt_d = cnt_q + DebW'(1);
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (frame_res == KeyNone) begin
                        if (rcnt_q + DebW'(1) == DebTarget) begin
                            rcnt_d  = '0;
                            state_d = StIdle;
                        end else begin
                            rcnt_d = rcnt_q + DebW'(1);
                        end
                    end else begin
                        rcnt_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        if (key_evt_q) begin
            if (key_code_q <= 4'd9) begin
                if (count_q < 3'd6) begin
                    digits_d = {digits_q[19:0], key_code_q};
                    count_d  = count_q + 3'd1;
                end
            end else if (key_code_q == KeyStar) begin
                if (count_q != 3'd0) begin
                    digits_d = {4'h0, digits_q[23:4]};
                    count_d  = count_q - 3'd1;
                end
            end else if (key_code_q == KeyHash) begin
                if (count_q != 3'd0) begin
                    value_d  = digits_q;
                    valid_d  = 1'b1;
                    digits_d = '0;
                    count_d  = 3'd0;
                end
            end
        end
    end

    // Select and data are both computed for the incoming slot so they switch together.
    always_comb begin
        ref_last  = (ref_cnt_q == RefLast);
        ref_cnt_d = ref_last ? '0 : ref_cnt_q + RefW'(1);
        dig_idx_d = dig_idx_q;
        sel_d     = sel_q;
        seg_d     = seg_q;
        nibble    = 4'h0;
        if (ref_last) begin
            dig_idx_d = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
            sel_d     = ~(6'b000001 << dig_idx_d);
            nibble    = digits_q[{dig_idx_d, 2'b00} +: 4];
            seg_d     = (dig_idx_d < count_q) ? seg_pattern(nibble) : 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            row_q      <= 3'b110;
            seen_q     <= 1'b0;
            bad_q      <= 1'b0;
            code_q     <= KeyNone;
            state_q    <= StIdle;
            cand_q     <= KeyNone;
            cnt_q      <= '0;
            rcnt_q     <= '0;
            key_evt_q  <= 1'b0;
            key_code_q <= KeyNone;
            digits_q   <= '0;
            count_q    <= 3'd0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            ref_cnt_q  <= '0;
            dig_idx_q  <= 3'd0;
            sel_q      <= 6'b111110;
            seg_q      <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            row_q      <= row_d;
            seen_q     <= seen_d;
            bad_q      <= bad_d;
            code_q     <= code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            key_evt_q  <= key_evt_d;
            key_code_q <= key_code_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            ref_cnt_q  <= ref_cnt_d;
            dig_idx_q  <= dig_idx_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign keypadRow     = row_q;
    assign segmentSelect = sel_q;
    assign segmentData   = seg_q;
    assign entry_value   = value_q;
    assign entry_valid   = valid_q;
    assign entry_count   = count_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: keypad matrix model, digit-buffer model and a
// scoreboard of expected entry_value results checked whenever entry_valid pulses.
module tb_keypad_entry_ctrl;

    localparam int SCAN  = 4;
    localparam int DEB   = 3;
    localparam int REF   = 2;
    localparam int FRAME = 3 * SCAN;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  keypadCol;
    logic [2:0]  keypadRow;
    logic [5:0]  segmentSelect;
    logic [7:0]  segmentData;
    logic [23:0] entry_value;
    logic        entry_valid;
    logic [2:0]  entry_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] pressed = '0;
    logic [23:0] model_buf = '0;
    int          model_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] sb_exp;
    logic [7:0]  disp_cap[6];
    logic        prev_valid = 1'b0;

    keypad_entry_ctrl #(
        .SCAN_DIV      (SCAN),
        .DEBOUNCE_SCANS(DEB),
        .REFRESH_DIV   (REF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keypadCol    (keypadCol),
        .keypadRow    (keypadRow),
        .segmentSelect(segmentSelect),
        .segmentData  (segmentData),
        .entry_value  (entry_value),
        .entry_valid  (entry_valid),
        .entry_count  (entry_count)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        keypadCol = 4'hF;
        for (int r = 0; r < 3; r++) begin
            if (!keypadRow[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) keypadCol[c] = 1'b0;
                end
            end
        end
    end

    function automatic int key_pos(input int key);
        case (key)
            1: return 0;   2: return 1;   3: return 2;   10: return 3;
            4: return 4;   5: return 5;   6: return 6;   11: return 7;
            7: return 8;   8: return 9;   9: return 10;  default: return 11;
        endcase
    endfunction

    function automatic logic [7:0] pat(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;  4'd3: return 8'hB0;
            4'd4: return 8'h99;  4'd5: return 8'h92;  4'd6: return 8'h82;  4'd7: return 8'hF8;
            4'd8: return 8'h80;  4'd9: return 8'h90;  default: return 8'hFF;
        endcase
    endfunction

    task automatic model_apply(input int key);
        if (key <= 9) begin
            if (model_cnt < 6) begin
                model_buf = {model_buf[19:0], key[3:0]};
                model_cnt++;
            end
        end else if (key == 10) begin
            if (model_cnt > 0) begin
                model_buf = {4'h0, model_buf[23:4]};
                model_cnt--;
            end
        end else if (model_cnt > 0) begin
            exp_q.push_back(model_buf);
            model_buf = '0;
            model_cnt = 0;
        end
    endtask

    task automatic press_key(input int key, input int hold_frames);
        model_apply(key);
        pressed[key_pos(key)] = 1'b1;
        repeat (hold_frames * FRAME) @(negedge clk);
        pressed = '0;
        repeat (5 * FRAME) @(negedge clk);
    endtask

    task automatic capture_display();
        for (int i = 0; i < 6; i++) disp_cap[i] = 8'h00;
        repeat (2 * 6 * REF) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (segmentSelect == ~(6'b000001 << i)) disp_cap[i] = segmentData;
            end
        end
    endtask

    // Scoreboard side: every entry_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (entry_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL entry_valid_unexpected: got pulse value=%h, expected no pulse",
                         entry_value);
            end else begin
                sb_exp = exp_q.pop_front();
                if (entry_value !== sb_exp) begin
                    miscompares++;
                    $display("FAIL entry_value: got %h, expected %h", entry_value, sb_exp);
                end
            end
            vectors++;
            if (prev_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL entry_valid_width: got >1 cycle, expected 1 cycle");
            end
            vectors++;
            if (entry_count !== 3'd0) begin
                miscompares++;
                $display("FAIL count_after_enter: got %0d, expected 0", entry_count);
            end
        end
        prev_valid = entry_valid;
    end

    task automatic test_reset();
        logic [2:0] exp_row;
        logic [5:0] exp_sel;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (keypadRow !== 3'b110) begin
            miscompares++; $display("FAIL reset_row: got %b, expected 110", keypadRow);
        end
        vectors++;
        if (segmentSelect !== 6'b111110) begin
            miscompares++; $display("FAIL reset_sel: got %b, expected 111110", segmentSelect);
        end
        vectors++;
        if (segmentData !== 8'hFF) begin
            miscompares++; $display("FAIL reset_seg: got %h, expected FF", segmentData);
        end
        vectors++;
        if (entry_value !== 24'h0 || entry_valid !== 1'b0 || entry_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_entry: got value=%h valid=%b count=%0d, expected 0/0/0",
                     entry_value, entry_valid, entry_count);
        end
        rst = 1'b1;
        for (int k = 0; k < 24; k++) begin
            exp_row = ~(3'b001 << ((k / SCAN) % 3));
            exp_sel = ~(6'b000001 << ((k / REF) % 6));
            vectors++;
            if (keypadRow !== exp_row || segmentSelect !== exp_sel || segmentData !== 8'hFF) begin
                miscompares++;
                $display("FAIL idle_scan k=%0d: got row=%b sel=%b seg=%h, expected %b %b FF",
                         k, keypadRow, segmentSelect, segmentData, exp_row, exp_sel);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        logic [2:0] prev_row;
        bit found = 0;
        prev_row = keypadRow;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (prev_row == 3'b011 && keypadRow == 3'b110) found = 1;
            prev_row = keypadRow;
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL frame_align: got no frame start, expected one");
        end
        pressed[key_pos(3)] = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        pressed = '0;
        repeat (FRAME) @(negedge clk);
        pressed[key_pos(3)] = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        pressed = '0;
        repeat (5 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'd0) begin
            miscompares++; $display("FAIL bounce_count: got %0d, expected 0", entry_count);
        end
    endtask

    task automatic test_single_key();
        logic [7:0] e;
        press_key(5, 5);
        vectors++;
        if (entry_count !== 3'(model_cnt)) begin
            miscompares++;
            $display("FAIL single_count: got %0d, expected %0d", entry_count, model_cnt);
        end
        capture_display();
        for (int i = 0; i < 6; i++) begin
            e = (i < model_cnt) ? pat(model_buf[i*4 +: 4]) : 8'hFF;
            vectors++;
            if (disp_cap[i] !== e) begin
                miscompares++;
                $display("FAIL single_digit%0d: got %h, expected %h", i, disp_cap[i], e);
            end
        end
        press_key(10, 5);
        vectors++;
        if (entry_count !== 3'(model_cnt)) begin
            miscompares++;
            $display("FAIL backspace_count: got %0d, expected %0d", entry_count, model_cnt);
        end
    endtask

    task automatic test_entry();
        logic [7:0] e;
        for (int k = 1; k <= 7; k++) press_key(k, 5);
        vectors++;
        if (entry_count !== 3'd6 || model_buf !== 24'h123456) begin
            miscompares++;
            $display("FAIL full_count: got %0d, expected 6", entry_count);
        end
        capture_display();
        for (int i = 0; i < 6; i++) begin
            e = (i < model_cnt) ? pat(model_buf[i*4 +: 4]) : 8'hFF;
            vectors++;
            if (disp_cap[i] !== e) begin
                miscompares++;
                $display("FAIL full_digit%0d: got %h, expected %h", i, disp_cap[i], e);
            end
        end
        press_key(10, 5);
        vectors++;
        if (entry_count !== 3'd5) begin
            miscompares++; $display("FAIL star_count: got %0d, expected 5", entry_count);
        end
        capture_display();
        for (int i = 0; i < 6; i++) begin
            e = (i < model_cnt) ? pat(model_buf[i*4 +: 4]) : 8'hFF;
            vectors++;
            if (disp_cap[i] !== e) begin
                miscompares++;
                $display("FAIL star_digit%0d: got %h, expected %h", i, disp_cap[i], e);
            end
        end
        press_key(11, 5);
        vectors++;
        if (entry_count !== 3'd0 || entry_value !== 24'h012345) begin
            miscompares++;
            $display("FAIL enter_state: got count=%0d value=%h, expected 0 012345",
                     entry_count, entry_value);
        end
        capture_display();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (disp_cap[i] !== 8'hFF) begin
                miscompares++;
                $display("FAIL enter_digit%0d: got %h, expected FF", i, disp_cap[i]);
            end
        end
    endtask

    task automatic test_ghost();
        pressed = '0;
        pressed[key_pos(1)] = 1'b1;
        pressed[key_pos(9)] = 1'b1;
        repeat (5 * FRAME) @(negedge clk);
        pressed = '0;
        repeat (5 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'd0) begin
            miscompares++; $display("FAIL two_rows_count: got %0d, expected 0", entry_count);
        end
        pressed[key_pos(1)] = 1'b1;
        pressed[key_pos(2)] = 1'b1;
        repeat (5 * FRAME) @(negedge clk);
        pressed = '0;
        repeat (5 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'd0) begin
            miscompares++; $display("FAIL two_cols_count: got %0d, expected 0", entry_count);
        end
        press_key(11, 5);
        press_key(10, 5);
        vectors++;
        if (entry_count !== 3'd0 || entry_value !== 24'h012345) begin
            miscompares++;
            $display("FAIL empty_keys: got count=%0d value=%h, expected 0 012345",
                     entry_count, entry_value);
        end
    endtask

    task automatic test_reset_midop();
        model_apply(8);
        pressed[key_pos(8)] = 1'b1;
        repeat (5 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'(model_cnt)) begin
            miscompares++;
            $display("FAIL held_count: got %0d, expected %0d", entry_count, model_cnt);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_buf = '0;
        model_cnt = 0;
        vectors++;
        if (keypadRow !== 3'b110 || segmentSelect !== 6'b111110 || segmentData !== 8'hFF) begin
            miscompares++;
            $display("FAIL midreset_disp: got row=%b sel=%b seg=%h, expected 110 111110 FF",
                     keypadRow, segmentSelect, segmentData);
        end
        vectors++;
        if (entry_value !== 24'h0 || entry_valid !== 1'b0 || entry_count !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_entry: got value=%h valid=%b count=%0d, expected 0/0/0",
                     entry_value, entry_valid, entry_count);
        end
        rst = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'd0) begin
            miscompares++; $display("FAIL early_accept: got %0d, expected 0", entry_count);
        end
        model_apply(8);
        repeat (2 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'd1) begin
            miscompares++; $display("FAIL reaccept_count: got %0d, expected 1", entry_count);
        end
        repeat (5 * FRAME) @(negedge clk);
        pressed = '0;
        repeat (5 * FRAME) @(negedge clk);
        vectors++;
        if (entry_count !== 3'(model_cnt) || dut.digits_q[3:0] !== 4'd8) begin
            miscompares++;
            $display("FAIL no_repeat_count: got %0d, expected %0d", entry_count, model_cnt);
        end
        capture_display();
        vectors++;
        if (disp_cap[0] !== 8'h80) begin
            miscompares++; $display("FAIL reaccept_digit0: got %h, expected 80", disp_cap[0]);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_key();
        test_entry();
        test_ghost();
        test_reset_midop();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "time limit reached");
    end

endmodule
